dr_sync_mc: RTL and testbench
=============================

// Module: dr_sync_mc
// PURPOSE
//  Multi-channel dual-rail to synchronous bridge; successor to the single-channel sync block.
//  Terminates CH asynchronous dual-rail links (4-phase RTZ or 2-phase NRZ) and synchronises them into clk.
//  Buffers each channel's tokens in a private FIFO and merges them onto one valid/ready stream tagged with channel index.
//  Sits between async pipelines (e.g. fib_fp) and clocked consumers/debug ports.
// PARAMETERS
//  WIDTH       8     data bits per token (2 rails each)
//  CH          4     number of input channels, >=1
//  DEPTH       4     per-channel FIFO depth, power of 2, >=2
//  SYNC_STAGES 2     flop stages on every input rail, >=2
//  ENC         "FP"  "FP" = 4-phase RTZ dual-rail; "TP" = 2-phase NRZ dual-rail
// PORTS
//  clk        in   1                 system clock
//  rst        in   1                 asynchronous, active-high reset
//  in         in   [CH][WIDTH][2]    dual-rail rails per channel; [1]=true, [0]=false rail
//  ack_o      out  [CH]              per-channel acknowledge to async sender
//  out_data   out  WIDTH             decoded token
//  out_ch     out  max(1,clog2(CH))  source channel of out_data
//  out_valid  out  1                 out_data/out_ch valid
//  out_ready  in   1                 consumer accepts when out_valid&&out_ready
//  err        out  [CH]              sticky illegal-code flag per channel
// BEHAVIOUR
//  Reset (async assert, sync release): ack_o=0, out_valid=0, out_data=0, out_ch=0, err=0,
//   FIFOs empty, TP reference rails=0, RR pointer=0, all sync flops=0.
//  Rails pass SYNC_STAGES flops; all logic below uses synchronised rails s[c].
//  FP channel FSM (per channel):
//   IDLE: every bit has exactly one rail high and FIFO not full -> push decoded word
//         (bit=true rail), ack_o<=1, go ACK. Complete but FIFO full -> stay IDLE, ack_o=0.
//   ACK : all rails low -> ack_o<=0, go IDLE. Otherwise hold.
//   Any bit with both rails high in IDLE -> err[c]<=1, FSM frozen (no push, ack unchanged)
//   until rst.
//  TP channel: ref[c] = rails at last capture. Bit complete when exactly one of its rails
//   differs from ref; value = true rail toggled. All bits complete and FIFO not full ->
//   push, ref<=s[c], ack_o[c]<=~ack_o[c]. Any bit with both rails toggled -> err[c]<=1,
//   channel frozen.
//  Latency: rail change -> push and ack edge on same clk edge, SYNC_STAGES+1 cycles after
//   the last rail settles; push -> out_valid >=1 cycle (registered output stage).
//  Partial codes (some bits not yet complete) never push; monotonic rail arrival guarantees
//   correct data once complete.
//  Arbiter: round-robin over non-empty FIFOs starting at RR pointer; loads output register
//   when it is empty or being drained this cycle (out_ready&&out_valid) -> zero bubble at
//   full throughput. After grant to c, pointer=c+1 mod CH (wraps CH-1 -> 0).
//  Output stable: out_data/out_ch/out_valid held unchanged while out_valid&&!out_ready.
//  Simultaneous push and pop on one FIFO in one cycle: both happen; level unchanged;
//   allowed when full (pop frees slot, but push gated by pre-pop full flag -> push waits one
//   cycle).
//  Pointers WIDTH log2(DEPTH)+1 for full/empty distinction; wrap naturally.
//  rst mid-handshake: ack_o drops immediately; sender must be reset with the same rst.
// TESTING
//  FP CH=4: send 0xA5 on ch2 -> out_data=0xA5, out_ch=2, ack_o[2] rises then falls after nulls.
//  Backpressure: out_ready=0, 5 tokens on ch0 (DEPTH=4) -> 4 acked + 1 output reg (5 held),
//   6th token: ack_o[0] stays 0 until out_ready=1, then ordered drain.
//  All 4 channels token each cycle, out_ready=1 -> grants 0,1,2,3,0,... no starvation,
//   no bubble.
//  FP bit3 both rails high on ch1 -> err[1]=1, no push, other channels keep flowing; rst
//   clears.
//  TP mode: tokens 0x00,0xFF,0x3C on ch3 -> same words out, ack_o[3] toggles 3 times;
//   double toggle -> err[3].
//  Assert rst while ch0 in ACK with FIFO half full -> ack_o=0, out_valid=0, FIFOs empty
//   next cycle.

Source files
------------

// File: rtl/dr_sync_mc.sv
// dr_sync_mc: multi-channel dual-rail (4-phase RTZ or 2-phase NRZ) to synchronous bridge.
// Each channel is synchronised, decoded into a private FIFO, and the FIFOs are merged
// round-robin onto one registered valid/ready stream tagged with the source channel.
module dr_sync_mc #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CH          = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter string       ENC         = "FP",
    localparam int unsigned CW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CH-1:0][WIDTH-1:0][1:0] in,
    output logic [CH-1:0]                 ack_o,
    output logic [WIDTH-1:0]              out_data,
    output logic [CW-1:0]                 out_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH-1:0]                 err
);
    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam bit            IS_TP   = (ENC == "TP");
    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);

    typedef enum logic {StIdle, StAck} fp_state_e;

    logic [CH-1:0][WIDTH-1:0][1:0] sync_q [SYNC_STAGES];
    logic [CH-1:0][WIDTH-1:0][1:0] s;
    logic [CH-1:0][WIDTH-1:0][1:0] ref_q, ref_d;

    fp_state_e state_q [CH];
    fp_state_e state_d [CH];
    logic [CH-1:0] ack_q, ack_d, err_q, err_d;

    logic [CH-1:0] fp_done, fp_bad, fp_null, tp_done, tp_bad;
    logic [CH-1:0][WIDTH-1:0] push_word;
    logic [CH-1:0] push, pop, full, empty;

    logic [WIDTH-1:0] mem_q [CH][DEPTH];
    logic [AW:0]      wptr_q [CH];
    logic [AW:0]      rptr_q [CH];

    logic             grant_valid, load;
    logic [CW-1:0]    grant_idx, rr_q;
    logic [WIDTH-1:0] head;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CW-1:0]    out_ch_q;

    // Input rail synchronisers; every downstream decision uses only the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end
    assign s = sync_q[SYNC_STAGES-1];

    // Classify each channel's code for both encodings and form the word to push
    always_comb begin
        logic             f_done, f_bad, f_null, t_done, t_bad;
        logic [1:0]       d;
        logic [WIDTH-1:0] w;
        for (int c = 0; c < CH; c++) begin
            f_done = 1'b1;
            f_bad  = 1'b0;
            f_null = 1'b1;
            t_done = 1'b1;
            t_bad  = 1'b0;
            w      = '0;
            for (int b = 0; b < WIDTH; b++) begin
                d      = s[c][b] ^ ref_q[c][b];
                f_done = f_done & (s[c][b][1] ^ s[c][b][0]);
                f_bad  = f_bad | (s[c][b][1] & s[c][b][0]);
                f_null = f_null & ~(s[c][b][1] | s[c][b][0]);
                t_done = t_done & (d[1] ^ d[0]);
                t_bad  = t_bad | (d[1] & d[0]);
                // TP: a toggled true rail means 1
                w[b]   = IS_TP ? d[1] : s[c][b][1];
            end
            fp_done[c]   = f_done;
            fp_bad[c]    = f_bad;
            fp_null[c]   = f_null;
            tp_done[c]   = t_done;
            tp_bad[c]    = t_bad;
            push_word[c] = w;
        end
    end

    // FIFO status; pointers carry one extra bit to tell full from empty
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            full[c]  = (wptr_q[c][AW] != rptr_q[c][AW]) &&
                       (wptr_q[c][AW-1:0] == rptr_q[c][AW-1:0]);
            empty[c] = (wptr_q[c] == rptr_q[c]);
        end
    end

    // Channel handshake next-state: push, ack and sticky error per channel
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            state_d[c] = state_q[c];
            ack_d[c]   = ack_q[c];
            err_d[c]   = err_q[c];
            ref_d[c]   = ref_q[c];
            push[c]    = 1'b0;
            if (!err_q[c]) begin
                if (IS_TP) begin
                    if (tp_bad[c]) begin
                        err_d[c] = 1'b1;
                    end else if (tp_done[c] && !full[c]) begin
                        push[c]  = 1'b1;
                        ref_d[c] = s[c];
                        ack_d[c] = ~ack_q[c];
                    end
                end else begin
                    case (state_q[c])
                        StIdle: begin
                            if (fp_bad[c]) begin
                                err_d[c] = 1'b1;
                            end else if (fp_done[c] && !full[c]) begin
                                push[c]    = 1'b1;
                                ack_d[c]   = 1'b1;
                                state_d[c] = StAck;
                            end
                        end
                        StAck: begin
                            if (fp_null[c]) begin
                                ack_d[c]   = 1'b0;
                                state_d[c] = StIdle;
                            end
                        end
                        default: state_d[c] = StIdle;
                    endcase
                end
            end
        end
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) state_q[c] <= StIdle;
            ack_q <= '0;
            err_q <= '0;
            ref_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            ref_q   <= ref_d;
        end
    end

    // FIFO pointers; push and pop may coincide on one channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (push[c]) wptr_q[c] <= wptr_q[c] + PTR_ONE;
                if (pop[c])  rptr_q[c] <= rptr_q[c] + PTR_ONE;
            end
        end
    end

    // FIFO storage needs no reset; occupancy is defined by the pointers
    always_ff @(posedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (push[c]) mem_q[c][wptr_q[c][AW-1:0]] <= push_word[c];
        end
    end

    // Round-robin pick of the first non-empty FIFO at or after the pointer
    always_comb begin
        int unsigned   idx;
        logic [CW-1:0] idx_c;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < CH; k++) begin
            idx   = (32'(rr_q) + k) % CH;
            idx_c = CW'(idx);
            if (!grant_valid && !empty[idx_c]) begin
                grant_valid = 1'b1;
                grant_idx   = idx_c;
            end
        end
        // Reload when empty or draining this cycle so back-to-back words have no bubble
        load = !out_valid_q || out_ready;
        pop  = '0;
        if (load && grant_valid) pop[grant_idx] = 1'b1;
        head = mem_q[grant_idx][rptr_q[grant_idx][AW-1:0]];
    end

    // Registered output stage and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_q        <= '0;
        end else if (load) begin
            out_valid_q <= grant_valid;
            if (grant_valid) begin
                out_data_q <= head;
                out_ch_q   <= grant_idx;
                rr_q       <= (grant_idx == CH_LAST) ? '0 : grant_idx + CW'(1);
            end
        end
    end

    assign ack_o     = ack_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_dr_sync_mc.sv
// Bench for dr_sync_mc: one FP and one TP instance, scoreboard-checked output stream.
module tb_dr_sync_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [3:0][7:0][1:0] in_fp, in_tp;
    logic [3:0]           ack_fp, ack_tp, err_fp, err_tp;
    logic [7:0]           out_data_fp, out_data_tp;
    logic [1:0]           out_ch_fp, out_ch_tp;
    logic                 out_valid_fp, out_valid_tp, ready_fp, ready_tp;

    dr_sync_mc #(.WIDTH(8), .CH(4), .DEPTH(4), .SYNC_STAGES(2), .ENC("FP")) u_fp (
        .clk(clk), .rst(rst), .in(in_fp), .ack_o(ack_fp), .out_data(out_data_fp),
        .out_ch(out_ch_fp), .out_valid(out_valid_fp), .out_ready(ready_fp), .err(err_fp)
    );

    dr_sync_mc #(.WIDTH(8), .CH(4), .DEPTH(4), .SYNC_STAGES(2), .ENC("TP")) u_tp (
        .clk(clk), .rst(rst), .in(in_tp), .ack_o(ack_tp), .out_data(out_data_tp),
        .out_ch(out_ch_tp), .out_valid(out_valid_tp), .out_ready(ready_tp), .err(err_tp)
    );

    typedef struct {int ch; logic [7:0] data;} exp_t;
    typedef struct {int ch; logic [7:0] data; int exp_ch; logic [7:0] exp_data;} vec_t;

    exp_t       q_fp[$];
    exp_t       q_tp[$];
    int         errors = 0;
    int         checks = 0;
    logic       stall [2];
    logic [1:0] pch [2];
    logic [7:0] pdat [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor: hold-stability while stalled, scoreboard compare on each transfer
    task automatic mon(input int w, input logic v, input logic r, input logic [1:0] c,
                       input logic [7:0] d);
        exp_t e;
        if (stall[w]) begin
            chk("hold_valid", 32'(v), 1);
            chk("hold_ch", 32'(c), 32'(pch[w]));
            chk("hold_data", 32'(d), 32'(pdat[w]));
        end
        stall[w] = v && !r;
        pch[w]   = c;
        pdat[w]  = d;
        if (v && r) begin
            if ((w == 0) ? (q_fp.size() == 0) : (q_tp.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out dut%0d: got ch=%0d data=%0h expected none",
                         w, c, d);
            end else begin
                e = (w == 0) ? q_fp.pop_front() : q_tp.pop_front();
                chk("out_ch", 32'(c), e.ch);
                chk("out_data", 32'(d), 32'(e.data));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall[0] = 1'b0;
            stall[1] = 1'b0;
        end else begin
            mon(0, out_valid_fp, ready_fp, out_ch_fp, out_data_fp);
            mon(1, out_valid_tp, ready_tp, out_ch_tp, out_data_tp);
        end
    end

    task automatic fp_put(input int c, input logic [7:0] v);
        for (int b = 0; b < 8; b++) in_fp[c][b] = {v[b], ~v[b]};
    endtask

    task automatic fp_null(input int c);
        in_fp[c] = '0;
    endtask

    task automatic wait_ack(input int c, input logic lvl, input int budget, input string name);
        int n = 0;
        while (ack_fp[c] !== lvl && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(ack_fp[c]), 32'(lvl));
    endtask

    task automatic fp_send(input int c, input logic [7:0] v);
        q_fp.push_back('{ch: c, data: v});
        fp_put(c, v);
        wait_ack(c, 1'b1, 40, "fp_ack_rise");
        fp_null(c);
        wait_ack(c, 1'b0, 40, "fp_ack_fall");
    endtask

    task automatic tp_send(input int c, input logic [7:0] v);
        logic prev;
        int   n = 0;
        prev = ack_tp[c];
        q_tp.push_back('{ch: c, data: v});
        for (int b = 0; b < 8; b++) begin
            if (v[b]) in_tp[c][b][1] = ~in_tp[c][b][1];
            else      in_tp[c][b][0] = ~in_tp[c][b][0];
        end
        while (ack_tp[c] === prev && n < 40) begin
            tick();
            n++;
        end
        chk("tp_ack_toggle", 32'(ack_tp[c]), 32'(!prev));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q_fp.size() != 0 || q_tp.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_fp", q_fp.size(), 0);
        chk("drain_tp", q_tp.size(), 0);
    endtask

    task automatic rst_pulse();
        rst   = 1'b1;
        in_fp = '0;
        in_tp = '0;
        q_fp.delete();
        q_tp.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        vec_t tbl [6];
        logic seen;
        tbl[0] = '{ch: 0, data: 8'h00, exp_ch: 0, exp_data: 8'h00};
        tbl[1] = '{ch: 1, data: 8'hFF, exp_ch: 1, exp_data: 8'hFF};
        tbl[2] = '{ch: 3, data: 8'h5A, exp_ch: 3, exp_data: 8'h5A};
        tbl[3] = '{ch: 2, data: 8'h01, exp_ch: 2, exp_data: 8'h01};
        tbl[4] = '{ch: 0, data: 8'h80, exp_ch: 0, exp_data: 8'h80};
        tbl[5] = '{ch: 1, data: 8'h69, exp_ch: 1, exp_data: 8'h69};

        rst      = 1'b1;
        in_fp    = '0;
        in_tp    = '0;
        ready_fp = 1'b1;
        ready_tp = 1'b1;
        stall[0] = 1'b0;
        stall[1] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_ack_fp", 32'(ack_fp), 0);
        chk("rst_valid_fp", 32'(out_valid_fp), 0);
        chk("rst_data_fp", 32'(out_data_fp), 0);
        chk("rst_ch_fp", 32'(out_ch_fp), 0);
        chk("rst_err_fp", 32'(err_fp), 0);
        chk("rst_ack_tp", 32'(ack_tp), 0);
        chk("rst_valid_tp", 32'(out_valid_tp), 0);

        // 0xA5 on ch2: ack rises exactly SYNC_STAGES+1 edges after the rails settle
        q_fp.push_back('{ch: 2, data: 8'hA5});
        fp_put(2, 8'hA5);
        tick();
        tick();
        chk("lat_ack_early", 32'(ack_fp[2]), 0);
        tick();
        chk("lat_ack_edge", 32'(ack_fp[2]), 1);
        fp_null(2);
        wait_ack(2, 1'b0, 40, "a5_ack_fall");

        // Table-driven tokens
        for (int i = 0; i < 6; i++) begin
            q_fp.push_back('{ch: tbl[i].exp_ch, data: tbl[i].exp_data});
            fp_put(tbl[i].ch, tbl[i].data);
            wait_ack(tbl[i].ch, 1'b1, 40, "tbl_ack_rise");
            fp_null(tbl[i].ch);
            wait_ack(tbl[i].ch, 1'b0, 40, "tbl_ack_fall");
        end
        drain(100);

        // TP: three tokens on ch3, ack toggles each time, then a double toggle
        tp_send(3, 8'h00);
        tp_send(3, 8'hFF);
        tp_send(3, 8'h3C);
        chk("tp_ack_after3", 32'(ack_tp[3]), 1);
        drain(100);
        in_tp[3][0] = ~in_tp[3][0];
        repeat (8) tick();
        chk("tp_err", 32'(err_tp), 32'h8);
        chk("tp_err_ack_held", 32'(ack_tp[3]), 1);
        chk("tp_err_no_out", 32'(out_valid_tp), 0);

        // Backpressure: 5 tokens held, 6th waits for the consumer
        rst_pulse();
        ready_fp = 1'b0;
        for (int i = 0; i < 5; i++) fp_send(0, 8'h40 + 8'(i));
        q_fp.push_back('{ch: 0, data: 8'h45});
        fp_put(0, 8'h45);
        repeat (20) tick();
        chk("bp_ack_blocked", 32'(ack_fp[0]), 0);
        chk("bp_valid_held", 32'(out_valid_fp), 1);
        ready_fp = 1'b1;
        wait_ack(0, 1'b1, 40, "bp_ack_after_drain");
        fp_null(0);
        wait_ack(0, 1'b0, 40, "bp_ack_fall");
        drain(100);

        // Round robin: all four channels at once, first round pre-loaded then released
        rst_pulse();
        ready_fp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            q_fp.push_back('{ch: c, data: 8'h10 + 8'(c)});
            fp_put(c, 8'h10 + 8'(c));
        end
        for (int c = 0; c < 4; c++) wait_ack(c, 1'b1, 40, "rr_ack_rise");
        for (int c = 0; c < 4; c++) fp_null(c);
        for (int c = 0; c < 4; c++) wait_ack(c, 1'b0, 40, "rr_ack_fall");
        tick();
        ready_fp = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("rr_no_bubble", 32'(out_valid_fp), 1);
        end
        @(negedge clk);
        #1;
        chk("rr_done", 32'(out_valid_fp), 0);
        tick();
        for (int c = 0; c < 4; c++) begin
            q_fp.push_back('{ch: c, data: 8'h20 + 8'(c)});
            fp_put(c, 8'h20 + 8'(c));
        end
        for (int c = 0; c < 4; c++) wait_ack(c, 1'b1, 40, "rr2_ack_rise");
        for (int c = 0; c < 4; c++) fp_null(c);
        for (int c = 0; c < 4; c++) wait_ack(c, 1'b0, 40, "rr2_ack_fall");
        drain(100);

        // Illegal code on ch1 bit3; ch0 keeps flowing; reset clears the flag
        rst_pulse();
        in_fp[1][3] = 2'b11;
        repeat (8) tick();
        chk("fp_err", 32'(err_fp), 32'h2);
        chk("fp_err_no_ack", 32'(ack_fp[1]), 0);
        chk("fp_err_no_out", 32'(out_valid_fp), 0);
        fp_send(0, 8'h3C);
        drain(100);
        chk("fp_err_sticky", 32'(err_fp), 32'h2);
        rst_pulse();
        chk("fp_err_cleared", 32'(err_fp), 0);

        // Reset while ch0 is in ACK with a partly filled FIFO
        ready_fp = 1'b0;
        fp_send(0, 8'h11);
        fp_send(0, 8'h22);
        q_fp.push_back('{ch: 0, data: 8'h33});
        fp_put(0, 8'h33);
        wait_ack(0, 1'b1, 40, "mid_ack_rise");
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack_fp[0]), 0);
        chk("mid_rst_valid", 32'(out_valid_fp), 0);
        in_fp = '0;
        in_tp = '0;
        q_fp.delete();
        q_tp.delete();
        tick();
        rst      = 1'b0;
        ready_fp = 1'b1;
        seen     = 1'b0;
        repeat (10) begin
            tick();
            if (out_valid_fp) seen = 1'b1;
        end
        chk("mid_rst_fifo_empty", 32'(seen), 0);

        chk("final_q_fp", q_fp.size(), 0);
        chk("final_q_tp", q_tp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
